// File: rtl/uart_rx_fifo_if.sv
// Pop-side bus of the UART receiver: head byte, occupancy and sticky error flags.
// Latency: none, wires only. Backpressure: the consumer drives data_out_ready.
// The master modport is the receiver and the slave modport is the CPU memory stage.
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [7:0]    data_out;
    logic          data_out_valid;
    logic          data_out_ready;
    logic [CW-1:0] count;
    logic          overrun;
    logic          frame_err;
    logic          err_clr;

    modport master (
        output data_out, data_out_valid, count, overrun, frame_err,
        input  data_out_ready, err_clr
    );

    modport slave (
        input  data_out, data_out_valid, count, overrun, frame_err,
        output data_out_ready, err_clr
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 2-flop synchroniser feeding a FWFT byte FIFO; stop-bit check under UART_RX_FRAME_ERR_EN.
// Latency: data_out_valid rises 1 clk after the stop-bit mid sample; data_out is combinational from the head.
// Backpressure: none toward the line; a byte arriving at full (without a same-cycle pop) is dropped and sets overrun.
module uart_rx_fifo #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            serial_in,
    uart_rx_fifo_if.master  rx
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);
    localparam int PTR_W            = $clog2(FIFO_DEPTH);
    localparam int CW               = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_nxt;
    logic             sync_q1, rx_s;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_q;
    logic             cnt_last, cnt_half;
    logic             sample_bit, push_req;
`ifdef UART_RX_FRAME_ERR_EN
    logic             frame_bad;
`endif

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]    count_q;
    logic             pop, push, overrun_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync_q1 <= serial_in;
            rx_s    <= sync_q1;
        end
    end

    assign cnt_last = (bit_cnt == LAST_CNT);
    assign cnt_half = (bit_cnt == HALF_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        sample_bit = 1'b0;
        push_req   = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        frame_bad  = 1'b0;
`endif
        case (state)
            IDLE:  if (!rx_s) state_nxt = START;
            START: if (cnt_half) state_nxt = rx_s ? IDLE : DATA;
            DATA: begin
                if (cnt_last) begin
                    sample_bit = 1'b1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (cnt_last) begin
                    state_nxt = IDLE;
`ifdef UART_RX_FRAME_ERR_EN
                    if (!rx_s) frame_bad = 1'b1;
                    else       push_req  = 1'b1;
`else
                    push_req = 1'b1;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counter restarts on any state change and at the end of each bit period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            shift_q <= '0;
        end else begin
            if (state_nxt != state || state == IDLE || cnt_last) bit_cnt <= '0;
            else                                                bit_cnt <= bit_cnt + CNT_W'(1);
            if (state != DATA)   bit_idx <= '0;
            else if (sample_bit) bit_idx <= bit_idx + 3'd1;
            if (sample_bit) shift_q <= {rx_s, shift_q[7:1]};
        end
    end

    assign pop  = rx.data_out_ready && (count_q != '0);
    assign push = push_req && ((count_q != DEPTH_C) || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shift_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
            if (push_req && !push) overrun_q <= 1'b1;
            else if (rx.err_clr)   overrun_q <= 1'b0;
        end
    end

`ifdef UART_RX_FRAME_ERR_EN
    logic frame_err_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             frame_err_q <= 1'b0;
        else if (frame_bad)   frame_err_q <= 1'b1;
        else if (rx.err_clr)  frame_err_q <= 1'b0;
    end
    assign rx.frame_err = frame_err_q;
`else
    assign rx.frame_err = 1'b0;
`endif

    assign rx.data_out       = (count_q != '0) ? mem[rd_ptr] : 8'd0;
    assign rx.data_out_valid = (count_q != '0);
    assign rx.count          = count_q;
    assign rx.overrun        = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo against a queue-based reference model.
// Covers UART_RX_FRAME_ERR_EN both ways by following the same macro.
module tb_uart_rx_fifo;
    localparam int DEPTH = 8;
    localparam int BIT_T = 434;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic serial_in = 1'b1;
    int   checks = 0;
    int   errors = 0;

    byte unsigned q[$];
    bit   m_ovr = 1'b0;
    bit   m_fe  = 1'b0;

    uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) rx_if ();

    uart_rx_fifo #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(115200), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .rx        (rx_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(rx_if.count), 32'(q.size()));
        chk({tag, ".valid"}, 32'(rx_if.data_out_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk({tag, ".head"}, 32'(rx_if.data_out), 32'(q[0]));
        chk({tag, ".overrun"}, 32'(rx_if.overrun), 32'(m_ovr));
        chk({tag, ".frame_err"}, 32'(rx_if.frame_err), 32'(m_fe));
    endtask

    // Reference effect of one received frame on the FIFO and flags.
    task automatic model_frame(input byte unsigned b, input bit stop, input bit pop_pulse, input bit clr_pulse);
        bit popped = pop_pulse && (q.size() != 0);
        bit full   = (q.size() == DEPTH);
        bit bad    = 1'b0;
        bit dropped = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        bad = !stop;
`endif
        if (popped) void'(q.pop_front());
        if (!bad) begin
            if (!full || popped) q.push_back(b);
            else dropped = 1'b1;
        end
        if (dropped)        m_ovr = 1'b1;
        else if (clr_pulse) m_ovr = 1'b0;
        if (bad)            m_fe = 1'b1;
        else if (clr_pulse) m_fe = 1'b0;
    endtask

    // Drives one 8N1 frame starting at the current negedge; ready/err_clr can be
    // pulsed for exactly the cycle whose edge samples the middle of the stop bit.
    task automatic send_frame(input byte unsigned b, input bit stop, input bit pop_pulse, input bit clr_pulse);
        serial_in = 1'b0;
        repeat (BIT_T) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            repeat (BIT_T) @(negedge clk);
        end
        serial_in = stop;
        for (int i = 1; i <= BIT_T; i++) begin
            @(negedge clk);
            if (i == 219) begin
                rx_if.data_out_ready = pop_pulse;
                rx_if.err_clr        = clr_pulse;
            end
            if (i == 220) begin
                rx_if.data_out_ready = 1'b0;
                rx_if.err_clr        = 1'b0;
            end
        end
        serial_in = 1'b1;
        model_frame(b, stop, pop_pulse, clr_pulse);
    endtask

    task automatic pop_one(input string tag);
        chk({tag, ".pop_head"}, 32'(rx_if.data_out), 32'(q.size() != 0 ? q[0] : 8'd0));
        rx_if.data_out_ready = 1'b1;
        @(negedge clk);
        rx_if.data_out_ready = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        @(negedge clk);
    endtask

    initial begin
        byte unsigned rb;
        bit rp;
        rx_if.data_out_ready = 1'b0;
        rx_if.err_clr        = 1'b0;

        // Reset state
        repeat (5) @(negedge clk);
        chk("rst.data_out", 32'(rx_if.data_out), 32'h0);
        check_all("rst");
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte then pop
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        check_all("a5");
        chk("a5.data", 32'(rx_if.data_out), 32'hA5);
        pop_one("a5");
        check_all("a5_popped");

        // 100-cycle low glitch on idle line
        serial_in = 1'b0;
        repeat (100) @(negedge clk);
        serial_in = 1'b1;
        repeat (400) @(negedge clk);
        check_all("glitch");

        // Fill to full, ninth byte overflows while err_clr pulses: new error wins
        for (int i = 1; i <= 8; i++) send_frame(byte'(i), 1'b1, 1'b0, 1'b0);
        check_all("full8");
        send_frame(8'h09, 1'b1, 1'b0, 1'b1);
        check_all("ovr");
        chk("ovr.flag", 32'(rx_if.overrun), 32'h1);
        rx_if.err_clr = 1'b1;
        @(negedge clk);
        rx_if.err_clr = 1'b0;
        m_ovr = 1'b0;
        @(negedge clk);
        check_all("ovr_clr");

        // Push and pop in the same cycle at full
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        check_all("full_pp");
        while (q.size() > 0) pop_one("drain");
        check_all("drained");

        // Randomized bytes with random same-cycle pops
        for (int k = 0; k < 2; k++) begin
            rb = byte'($urandom_range(0, 255));
            rp = 1'($urandom_range(0, 1));
            send_frame(rb, 1'b1, rp, 1'b0);
            check_all("rand");
        end
        if ($urandom_range(0, 1) == 1) pop_one("rand_pop");
        check_all("rand_after");

        // Stop bit forced low
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        repeat (300) @(negedge clk);
        check_all("stop0");
        rx_if.err_clr = 1'b1;
        @(negedge clk);
        rx_if.err_clr = 1'b0;
        m_fe = 1'b0;
        m_ovr = 1'b0;
        @(negedge clk);
        check_all("fe_clr");

        // Reset during bit 4 of 0x7E
        rb = 8'h7E;
        serial_in = 1'b0;
        repeat (BIT_T) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            serial_in = rb[i];
            repeat (BIT_T) @(negedge clk);
        end
        serial_in = rb[4];
        repeat (200) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        serial_in = 1'b1;
        q.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst.data_out", 32'(rx_if.data_out), 32'h0);
        check_all("mid_rst");
        rst = 1'b1;
        repeat (BIT_T * 5) @(negedge clk);
        check_all("post_rst");
        send_frame(8'h12, 1'b1, 1'b0, 1'b0);
        check_all("x12");
        chk("x12.data", 32'(rx_if.data_out), 32'h12);
        pop_one("x12");
        check_all("end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
